ask_symbol_framer: RTL and testbench

Downstream consumer of the pseudo-random bit generator in the ASK transmit path. Frames the generator's bit stream into packets: a fixed 8-bit preamble, then PAYLOAD_BITS pseudo-random payload bits, then an idle gap. Each bit is held for SYMBOL_CYCLES clocks and on-off keys a square-wave carrier derived from the system clock. Its output drives the transmitter pin directly, and it tells the generator exactly when each bit is consumed.

---
 rtl/ask_symbol_framer_if.sv | 31 +++
 rtl/ask_symbol_framer.sv | 192 +++++++++++++++++++
 tb/tb_ask_symbol_framer.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/ask_symbol_framer_if.sv
// Signal bundle between the ASK symbol framer, its bit generator and the transmitter pin.
// The master side is the framer; the slave side is the generator/transmitter environment.
interface ask_symbol_framer_if;
  logic start;
  logic data_in;
  logic bit_req;
  logic tx_out;
  logic sym_bit;
  logic busy;
  logic done;

  modport master (
    input  start,
    input  data_in,
    output bit_req,
    output tx_out,
    output sym_bit,
    output busy,
    output done
  );

  modport slave (
    output start,
    output data_in,
    input  bit_req,
    input  tx_out,
    input  sym_bit,
    input  busy,
    input  done
  );
endinterface

// File: rtl/ask_symbol_framer.sv
// Frames a pseudo-random bit stream into preamble/payload/gap packets and on-off keys a
// square-wave carrier with each held symbol; bit_req tells the generator when a bit is taken.
module ask_symbol_framer #(
  parameter int unsigned CARRIER_DIV   = 4,
  parameter int unsigned SYMBOL_CYCLES = 32,
  parameter logic [7:0]  PREAMBLE      = 8'b10101010,
  parameter int unsigned PAYLOAD_BITS  = 16,
  parameter int unsigned GAP_CYCLES    = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  ask_symbol_framer_if.master bus
);

  localparam int unsigned CYC_MAX = (SYMBOL_CYCLES > GAP_CYCLES) ? SYMBOL_CYCLES : GAP_CYCLES;
  localparam int unsigned CYC_W   = (CYC_MAX > 1) ? $clog2(CYC_MAX) : 1;
  localparam int unsigned IDX_MAX = (PAYLOAD_BITS > 8) ? PAYLOAD_BITS : 8;
  localparam int unsigned IDX_W   = $clog2(IDX_MAX);
  localparam int unsigned CAR_W   = (CARRIER_DIV > 1) ? $clog2(CARRIER_DIV) : 1;

  localparam logic [CYC_W-1:0] SYM_LAST = CYC_W'(SYMBOL_CYCLES - 1);
  localparam logic [CYC_W-1:0] GAP_LAST = CYC_W'(GAP_CYCLES - 1);
  localparam logic [IDX_W-1:0] PRE_LAST = IDX_W'(7);
  localparam logic [IDX_W-1:0] PAY_LAST = IDX_W'(PAYLOAD_BITS - 1);
  localparam logic [CAR_W-1:0] CAR_LAST = CAR_W'(CARRIER_DIV - 1);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PREAMBLE = 2'd1,
    ST_PAYLOAD  = 2'd2,
    ST_GAP      = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [CYC_W-1:0] cyc_q, cyc_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CAR_W-1:0] car_q, car_d;
  logic             phase_q, phase_d;
  logic             sym_q, sym_d;

  logic             sym_end_s;
  logic             gap_end_s;
  logic             bit_req_s;
  logic             done_s;
  logic [2:0]       pre_sel_s;
  logic [CAR_W-1:0] car_step_s;
  logic             phase_step_s;

  assign sym_end_s = (cyc_q == SYM_LAST);
  assign gap_end_s = (cyc_q == GAP_LAST);
  assign pre_sel_s = 3'd6 - idx_q[2:0];

  // Strobe the generator on the last cycle of the final preamble symbol and of every
  // payload symbol but the last, so exactly PAYLOAD_BITS bits are consumed per frame.
  always_comb begin
    bit_req_s = 1'b0;
    done_s    = 1'b0;
    if ((state_q == ST_PREAMBLE) && sym_end_s && (idx_q == PRE_LAST)) begin
      bit_req_s = 1'b1;
    end else if ((state_q == ST_PAYLOAD) && sym_end_s && (idx_q != PAY_LAST)) begin
      bit_req_s = 1'b1;
    end else begin
      bit_req_s = 1'b0;
    end
    if ((state_q == ST_GAP) && gap_end_s) begin
      done_s = 1'b1;
    end else begin
      done_s = 1'b0;
    end
  end

  // Free-running carrier step used inside a symbol; symbol boundaries override it.
  always_comb begin
    car_step_s   = car_q;
    phase_step_s = phase_q;
    if (car_q == CAR_LAST) begin
      car_step_s   = {CAR_W{1'b0}};
      phase_step_s = ~phase_q;
    end else begin
      car_step_s   = car_q + CAR_W'(1);
      phase_step_s = phase_q;
    end
  end

  // Next-state logic: frame sequencing, bit index, symbol value and carrier restart.
  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    idx_d   = idx_q;
    car_d   = car_q;
    phase_d = phase_q;
    sym_d   = sym_q;
    case (state_q)
      ST_IDLE: begin
        car_d   = {CAR_W{1'b0}};
        phase_d = 1'b1;
        if (bus.start) begin
          state_d = ST_PREAMBLE;
          cyc_d   = {CYC_W{1'b0}};
          idx_d   = {IDX_W{1'b0}};
          sym_d   = PREAMBLE[7];
        end else begin
          sym_d   = 1'b0;
        end
      end
      ST_PREAMBLE: begin
        if (sym_end_s) begin
          cyc_d   = {CYC_W{1'b0}};
          car_d   = {CAR_W{1'b0}};
          phase_d = 1'b1;
          if (idx_q == PRE_LAST) begin
            state_d = ST_PAYLOAD;
            idx_d   = {IDX_W{1'b0}};
            sym_d   = bus.data_in;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            sym_d   = PREAMBLE[pre_sel_s];
          end
        end else begin
          cyc_d   = cyc_q + CYC_W'(1);
          car_d   = car_step_s;
          phase_d = phase_step_s;
        end
      end
      ST_PAYLOAD: begin
        if (sym_end_s) begin
          cyc_d   = {CYC_W{1'b0}};
          car_d   = {CAR_W{1'b0}};
          phase_d = 1'b1;
          if (idx_q == PAY_LAST) begin
            state_d = ST_GAP;
            idx_d   = {IDX_W{1'b0}};
            sym_d   = 1'b0;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            sym_d   = bus.data_in;
          end
        end else begin
          cyc_d   = cyc_q + CYC_W'(1);
          car_d   = car_step_s;
          phase_d = phase_step_s;
        end
      end
      ST_GAP: begin
        car_d   = {CAR_W{1'b0}};
        phase_d = 1'b1;
        sym_d   = 1'b0;
        if (gap_end_s) begin
          state_d = ST_IDLE;
          cyc_d   = {CYC_W{1'b0}};
        end else begin
          cyc_d   = cyc_q + CYC_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cyc_d   = {CYC_W{1'b0}};
        idx_d   = {IDX_W{1'b0}};
        car_d   = {CAR_W{1'b0}};
        phase_d = 1'b1;
        sym_d   = 1'b0;
      end
    endcase
  end

  // State and counter registers; reset aborts any frame in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cyc_q   <= {CYC_W{1'b0}};
      idx_q   <= {IDX_W{1'b0}};
      car_q   <= {CAR_W{1'b0}};
      phase_q <= 1'b1;
      sym_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      idx_q   <= idx_d;
      car_q   <= car_d;
      phase_q <= phase_d;
      sym_q   <= sym_d;
    end
  end

  // sym_q and phase_q are both flops, so the keyed carrier needs no extra stage.
  assign bus.tx_out  = sym_q & phase_q;
  assign bus.sym_bit = sym_q;
  assign bus.busy    = (state_q != ST_IDLE);
  assign bus.bit_req = bit_req_s;
  assign bus.done    = done_s;

endmodule

// File: tb/tb_ask_symbol_framer.sv
// Directed bench for ask_symbol_framer: a frame-position model checked every cycle,
// plus hand-computed literal expectations for preamble, payload, framing and abort.
module tb_ask_symbol_framer;
  localparam int CD = 2;
  localparam int SC = 8;
  localparam int PB = 4;
  localparam int GC = 5;
  localparam int FL = (8 + PB) * SC + GC;
  localparam int NS = FL + 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  ask_symbol_framer_if bus ();

  ask_symbol_framer #(
    .CARRIER_DIV  (CD),
    .SYMBOL_CYCLES(SC),
    .PREAMBLE     (8'b10101010),
    .PAYLOAD_BITS (PB),
    .GAP_CYCLES   (GC)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int vec_cnt  = 0;
  int miss_cnt = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Upstream generator: a fixed bit table that advances on every bit_req edge.
  logic [7:0]  pre_v = 8'b10101010;
  logic [31:0] gen_v = 32'h5A3C_E9DD;
  logic [4:0]  gidx  = 5'd0;
  assign bus.data_in = gen_v[gidx];
  always @(posedge clk) begin
    if (bus.bit_req) gidx <= gidx + 5'd1;
  end

  // Model: position t within the frame (-1 when idle) determines every output.
  int         t_m = -1;
  logic [4:0] mg  = 5'd0;
  logic [4:0] fb  = 5'd0;
  logic [4:0] exp_s;

  function automatic logic [4:0] model_out(input int t, input logic [4:0] base);
    logic s, ph, rq, dn;
    int   k;
    s = 1'b0; ph = 1'b1; rq = 1'b0; dn = 1'b0;
    if (t < 0) return 5'b00000;
    ph = (((t % SC) / CD) % 2) == 0;
    if (t < 8 * SC) begin
      s  = pre_v[7 - t / SC];
      rq = (t == 8 * SC - 1);
    end else if (t < (8 + PB) * SC) begin
      k  = (t - 8 * SC) / SC;
      s  = gen_v[base + 5'(k)];
      rq = ((t % SC) == SC - 1) && (k < PB - 1);
    end else begin
      s  = 1'b0;
      dn = (t == FL - 1);
    end
    return {rq, s & ph, s, 1'b1, dn};
  endfunction

  always_comb exp_s = model_out(t_m, fb);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      t_m <= -1;
    end else begin
      if (exp_s[4]) mg <= mg + 5'd1;
      if (t_m < 0) begin
        if (bus.start) begin
          t_m <= 0;
          fb  <= mg;
        end
      end else if (t_m == FL - 1) begin
        t_m <= -1;
      end else begin
        t_m <= t_m + 1;
      end
    end
  end

  always @(negedge clk) begin
    chk("outputs{req,tx,sym,busy,done}",
        32'({bus.bit_req, bus.tx_out, bus.sym_bit, bus.busy, bus.done}), 32'(exp_s));
  end

  logic req_a [NS];
  logic tx_a  [NS];
  logic sym_a [NS];
  logic busy_a[NS];
  logic done_a[NS];

  task automatic run_frame(input int pulse_at);
    @(negedge clk);
    #1 bus.start = 1'b1;
    @(posedge clk);
    #2 bus.start = 1'b0;
    for (int c = 0; c < NS; c++) begin
      @(negedge clk);
      req_a[c]  = bus.bit_req;
      tx_a[c]   = bus.tx_out;
      sym_a[c]  = bus.sym_bit;
      busy_a[c] = bus.busy;
      done_a[c] = bus.done;
      if (c == pulse_at)     #1 bus.start = 1'b1;
      if (c == pulse_at + 2) #1 bus.start = 1'b0;
    end
  endtask

  task automatic check_framing(input string tag);
    int bn, dn, dat, rn, rf, dbl;
    bn = 0; dn = 0; dat = -1; rn = 0; rf = -1; dbl = 0;
    for (int c = 0; c < NS; c++) begin
      bn += int'(busy_a[c]);
      dn += int'(done_a[c]);
      rn += int'(req_a[c]);
      if (done_a[c] && dat < 0) dat = c;
      if (req_a[c] && rf < 0) rf = c;
      if (c > 0 && req_a[c] && req_a[c-1]) dbl++;
    end
    chk({tag, " busy cycles"}, 32'(bn), 32'd101);
    chk({tag, " busy after frame"}, 32'(busy_a[NS-1]), 32'd0);
    chk({tag, " done pulses"}, 32'(dn), 32'd1);
    chk({tag, " done cycle"}, 32'(dat), 32'd100);
    chk({tag, " bit_req count"}, 32'(rn), 32'd4);
    chk({tag, " first bit_req cycle"}, 32'(rf), 32'd63);
    chk({tag, " bit_req back-to-back"}, 32'(dbl), 32'd0);
  endtask

  task automatic wait_done(input int bound);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < bound && !seen; i++) begin
      @(negedge clk);
      if (bus.done) seen = 1'b1;
    end
    if (!seen) chk("done timeout", 32'd0, 32'd1);
  endtask

  initial begin
    logic [7:0] b8;
    logic [3:0] b4;
    logic       acc;
    int         dcount;
    bus.start = 1'b0;
    #1 rst_n = 1'b0;
    bus.start = 1'b1;
    repeat (3) @(posedge clk);
    #1 chk("reset outputs with start held",
           32'({bus.bit_req, bus.tx_out, bus.sym_bit, bus.busy, bus.done}), 32'd0);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #2 bus.start = 1'b0;
    @(negedge clk);
    chk("start at first edge after release",
        32'({bus.busy, bus.sym_bit, bus.tx_out}), 32'b111);
    wait_done(200);
    repeat (2) @(negedge clk);

    // Single-cycle start, with a stray start pulse while busy.
    run_frame(20);
    for (int i = 0; i < 8; i++) b8[7-i] = tx_a[i];
    chk("carrier in a 1 symbol", 32'(b8), 32'b11001100);
    for (int k = 0; k < 8; k++) b8[7-k] = sym_a[k*SC];
    chk("preamble symbols", 32'(b8), 32'b10101010);
    acc = 1'b0;
    for (int i = SC; i < 2*SC; i++) acc |= tx_a[i];
    chk("carrier in a 0 symbol", 32'(acc), 32'd0);
    for (int k = 0; k < 4; k++) b4[3-k] = sym_a[64 + k*SC];
    chk("payload symbols", 32'(b4), 32'b1011);
    acc = 1'b0;
    for (int i = 96; i < 101; i++) acc |= tx_a[i];
    chk("tx in gap", 32'(acc), 32'd0);
    check_framing("frame");

    // Back-to-back frames with start held high.
    #1 bus.start = 1'b1;
    wait_done(200);
    @(negedge clk);
    chk("idle cycle between frames", 32'(bus.busy), 32'd0);
    @(negedge clk);
    chk("back-to-back restart", 32'({bus.busy, bus.sym_bit, bus.tx_out}), 32'b111);
    #1 bus.start = 1'b0;
    b8[7] = bus.sym_bit;
    for (int k = 1; k < 8; k++) begin
      repeat (SC) @(negedge clk);
      b8[7-k] = bus.sym_bit;
    end
    chk("back-to-back preamble", 32'(b8), 32'b10101010);
    wait_done(200);
    repeat (2) @(negedge clk);

    // Abort during the payload.
    #1 bus.start = 1'b1;
    @(posedge clk);
    #2 bus.start = 1'b0;
    for (int c = 0; c <= 70; c++) @(negedge clk);
    #1 rst_n = 1'b0;
    #1 chk("abort outputs",
           32'({bus.bit_req, bus.tx_out, bus.sym_bit, bus.busy, bus.done}), 32'd0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    dcount = 0;
    repeat (10) begin
      @(negedge clk);
      dcount += int'(bus.done);
    end
    chk("no done after abort", 32'(dcount), 32'd0);
    run_frame(-10);
    check_framing("post-abort frame");

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end
endmodule
